// File: rtl/comparator_pkg.sv
// -----------------------------------------------------------------------------
// comparator_pkg
// Shared definitions for the comparator sweep driver and its reference model:
//   - WIDTH_DEFAULT : default operand width
//   - CMP_LATENCY   : edges from driving a pair to sampling its flags
//   - ST_*          : 2-bit FSM state encoding (IDLE/SWEEP/DRAIN/DONE)
//   - flags_t       : packed {gt, eq, lt} result
//   - is_onehot3()  : true when exactly one flag is set
// -----------------------------------------------------------------------------
package comparator_pkg;

    localparam int WIDTH_DEFAULT = 2;
    localparam int CMP_LATENCY   = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } flags_t;

    function automatic logic is_onehot3(input flags_t f);
        return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
    endfunction

endpackage

// File: rtl/comparator_sweep_driver_if.sv
// -----------------------------------------------------------------------------
// comparator_sweep_driver_if
// Operand/result bus between the sweep driver and a registered comparator.
//   cmp_a, cmp_b           : operands (driver -> comparator)
//   cmp_gt, cmp_eq, cmp_lt : registered flags (comparator -> driver)
// Modports: master = sweep driver, slave = comparator.
// -----------------------------------------------------------------------------
interface comparator_sweep_driver_if
    import comparator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) ();

    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             cmp_lt;

    modport master (
        output cmp_a, cmp_b,
        input  cmp_gt, cmp_eq, cmp_lt
    );

    modport slave (
        input  cmp_a, cmp_b,
        output cmp_gt, cmp_eq, cmp_lt
    );

endinterface

// File: rtl/comparator_expect.sv
// -----------------------------------------------------------------------------
// comparator_expect
// Combinational reference comparator used by the sweep driver's self-check.
//   a_i, b_i : operands (WIDTH bits, unsigned)
//   flags_o  : {gt, eq, lt}, always exactly one-hot
// -----------------------------------------------------------------------------
module comparator_expect
    import comparator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output flags_t           flags_o
);

    assign flags_o = {a_i > b_i, a_i == b_i, a_i < b_i};

endmodule

// File: rtl/comparator_sweep_driver.sv
// -----------------------------------------------------------------------------
// comparator_sweep_driver
// Bring-up sequencer for a registered comparator: drives every (A,B) pair once,
// counts the returned gt/eq/lt flags and pulses done when the sweep completes.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : begin a sweep (honoured only in IDLE/DONE)
//   abort             : return to IDLE, freeze counters, no done pulse
//   cmp (master)      : operand/flag bus to the comparator
//   busy              : high in SWEEP/DRAIN
//   done              : one-cycle pulse in DONE
//   gt/eq/lt_cnt      : number of sampled flags that were 1
//   err_cnt, error    : failing results / sticky error (self-check build only)
//
// Configuration macro: CMP_SWEEP_SELFCHECK_EN
//   defined   - results are compared to an internal reference model
//   undefined - err_cnt and error are tied to 0
// -----------------------------------------------------------------------------
module comparator_sweep_driver
    import comparator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = 2 * WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    comparator_sweep_driver_if.master  cmp,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           gt_cnt,
    output logic [CNT_W-1:0]           eq_cnt,
    output logic [CNT_W-1:0]           lt_cnt,
    output logic [CNT_W-1:0]           err_cnt,
    output logic                       error
);

    localparam int              PW       = 2 * WIDTH;
    localparam logic [PW-1:0]   LAST_IDX = '1;

    logic [1:0]             state_q, state_d;
    logic [PW-1:0]          idx_q, idx_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    // vld_q[0]: a pair is on cmp_a/cmp_b; vld_q[CMP_LATENCY-1]: its flags are
    // visible this cycle.
    logic [CMP_LATENCY-1:0] vld_q, vld_d;
    logic [CNT_W-1:0]       gt_cnt_q, eq_cnt_q, lt_cnt_q;
    logic                   clear;
    logic                   sample;
    flags_t                 seen;

    assign seen = {cmp.cmp_gt, cmp.cmp_eq, cmp.cmp_lt};

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        vld_d   = {vld_q[CMP_LATENCY-2:0], 1'b0};
        clear   = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            vld_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        clear    = 1'b1;
                        a_d      = '0;
                        b_d      = '0;
                        idx_d    = PW'(1);
                        vld_d[0] = 1'b1;
                        state_d  = ST_SWEEP;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_SWEEP: begin
                    {a_d, b_d} = idx_q;
                    idx_d      = idx_q + PW'(1);
                    vld_d[0]   = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leave once the last pair has reached the sampling stage.
                    if (vld_q[CMP_LATENCY-2:0] == '0) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Abort freezes the counters on the very edge it is seen.
    assign sample = vld_q[CMP_LATENCY-1] && !abort;

    // NOTE: state uses non-blocking assignments so every register updates from
    // pre-edge values, independent of statement order.
    // NOTE: reset is asynchronous; every register here is reset, no memories.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            vld_q    <= '0;
            gt_cnt_q <= '0;
            eq_cnt_q <= '0;
            lt_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            vld_q   <= vld_d;
            if (clear) begin
                gt_cnt_q <= '0;
                eq_cnt_q <= '0;
                lt_cnt_q <= '0;
            end else if (sample) begin
                // Flags are counted independently; one-hot is not assumed.
                if (seen.gt) gt_cnt_q <= gt_cnt_q + CNT_W'(1);
                if (seen.eq) eq_cnt_q <= eq_cnt_q + CNT_W'(1);
                if (seen.lt) lt_cnt_q <= lt_cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef CMP_SWEEP_SELFCHECK_EN
    flags_t           exp_now;
    flags_t           exp_q;
    logic             fail;
    logic [CNT_W-1:0] err_cnt_q;
    logic             error_q;

    comparator_expect #(.WIDTH(WIDTH)) u_expect (
        .a_i     (a_q),
        .b_i     (b_q),
        .flags_o (exp_now)
    );

    // The driven pair itself is stage 0; one register carries its expected
    // flags alongside the comparator's own register stage.
    assign fail = sample && (!is_onehot3(seen) || (seen != exp_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q     <= '0;
            err_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            exp_q <= exp_now;
            if (clear) begin
                err_cnt_q <= '0;
                error_q   <= 1'b0;
            end else if (fail) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
                error_q   <= 1'b1;
            end
        end
    end

    assign err_cnt = err_cnt_q;
    assign error   = error_q;
`else
    assign err_cnt = '0;
    assign error   = 1'b0;
`endif

    assign cmp.cmp_a = a_q;
    assign cmp.cmp_b = b_q;
    assign busy      = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign gt_cnt    = gt_cnt_q;
    assign eq_cnt    = eq_cnt_q;
    assign lt_cnt    = lt_cnt_q;

endmodule

// File: tb/tb_comparator_sweep_driver.sv
// -----------------------------------------------------------------------------
// tb_comparator_sweep_driver
// Drives the sweep driver against a behavioural registered comparator with
// selectable faults (good / eq forced high / held in reset). Expected sweep
// totals come from a pair-by-pair arithmetic model and are queued at start;
// a monitor pops and compares them whenever done is seen.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_comparator_sweep_driver;
    import comparator_pkg::*;

    localparam int W        = 2;
    localparam int CW       = 2 * W + 1;
    localparam int NPAIR    = 1 << (2 * W);
    localparam int DONE_LAT = NPAIR + 1;   // edges from start edge to done
    localparam int ABORT_AT = 6;           // abort sampled at start edge + 6

    typedef enum int {M_GOOD, M_EQ1, M_STUCK0} mode_e;

    typedef struct {
        int     gt;
        int     eq;
        int     lt;
        int     err;
        bit     error;
        longint start_cyc;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, error;
    logic [CW-1:0] gt_cnt, eq_cnt, lt_cnt, err_cnt;

    mode_e  mode = M_GOOD;
    longint cyc  = 0;
    int     n_checks = 0;
    int     n_pass   = 0;
    exp_t   sb[$];

    comparator_sweep_driver_if #(.WIDTH(W)) bus ();

    comparator_sweep_driver #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .cmp     (bus),
        .busy    (busy),
        .done    (done),
        .gt_cnt  (gt_cnt),
        .eq_cnt  (eq_cnt),
        .lt_cnt  (lt_cnt),
        .err_cnt (err_cnt),
        .error   (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered comparator with injectable faults.
    logic gt_r, eq_r, lt_r;
    always @(posedge clk) begin
        if (mode == M_STUCK0) begin
            gt_r <= 1'b0; eq_r <= 1'b0; lt_r <= 1'b0;
        end else begin
            gt_r <= bus.cmp_a >  bus.cmp_b;
            eq_r <= bus.cmp_a == bus.cmp_b;
            lt_r <= bus.cmp_a <  bus.cmp_b;
        end
    end
    assign bus.cmp_gt = gt_r;
    assign bus.cmp_eq = eq_r | (mode == M_EQ1);
    assign bus.cmp_lt = lt_r;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Totals after the first npairs pairs (index p -> a = p / 2**W, b = p % 2**W).
    function automatic exp_t model(input mode_e m, input int npairs);
        exp_t e;
        e = '{gt: 0, eq: 0, lt: 0, err: 0, error: 1'b0, start_cyc: 0};
        for (int p = 0; p < npairs; p++) begin
            int a, b;
            bit g, q, l;
            a = p / (1 << W);
            b = p % (1 << W);
            g = (m != M_STUCK0) && (a > b);
            q = (m == M_EQ1) || ((m != M_STUCK0) && (a == b));
            l = (m != M_STUCK0) && (a < b);
            e.gt += int'(g);
            e.eq += int'(q);
            e.lt += int'(l);
`ifdef CMP_SWEEP_SELFCHECK_EN
            if (!(g == (a > b) && q == (a == b) && l == (a < b))) e.err++;
`endif
        end
        e.error = (e.err > 0);
        return e;
    endfunction

    // Monitor: every done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", longint'(done), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("gt_cnt",  gt_cnt,  e.gt);
                check("eq_cnt",  eq_cnt,  e.eq);
                check("lt_cnt",  lt_cnt,  e.lt);
                check("err_cnt", err_cnt, e.err);
                check("error",   error,   longint'(e.error));
                check("done_latency", cyc - e.start_cyc, DONE_LAT);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the start edge.
    task automatic launch(input mode_e m, input bit push);
        exp_t e;
        mode  = m;
        start = 1'b1;
        if (push) begin
            e = model(m, NPAIR);
            e.start_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drained(input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy || done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || busy) begin
            check("sweep_timeout_pending", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    busy,      0);
        check({tag, "_done"},    done,      0);
        check({tag, "_gt_cnt"},  gt_cnt,    0);
        check({tag, "_eq_cnt"},  eq_cnt,    0);
        check({tag, "_lt_cnt"},  lt_cnt,    0);
        check({tag, "_err_cnt"}, err_cnt,   0);
        check({tag, "_error"},   error,     0);
        check({tag, "_cmp_a"},   bus.cmp_a, 0);
        check({tag, "_cmp_b"},   bus.cmp_b, 0);
    endtask

    initial begin
        exp_t ab;
        int   n;

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good comparator, eq forced high, flags stuck at zero.
        launch(M_GOOD, 1'b1);   wait_drained(60);
        launch(M_EQ1, 1'b1);    wait_drained(60);
        launch(M_STUCK0, 1'b1); wait_drained(60);

        // start re-pulsed after pair 5 is driven: must be ignored.
        launch(M_GOOD, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drained(60);

        // start during the DONE cycle begins the next sweep at once.
        launch(M_GOOD, 1'b1);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("done_seen_before_restart", done, 1);
        launch(M_EQ1, 1'b1);
        check("busy_after_restart", busy, 1);
        wait_drained(60);

        // Abort: IDLE next cycle, counters frozen, no done.
        launch(M_GOOD, 1'b0);
        repeat (ABORT_AT - 1) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ab = model(M_GOOD, ABORT_AT - CMP_LATENCY);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_gt_cnt", gt_cnt, ab.gt);
        check("abort_eq_cnt", eq_cnt, ab.eq);
        check("abort_lt_cnt", lt_cnt, ab.lt);
        repeat (25) @(negedge clk);
        check("abort_frozen_gt", gt_cnt, ab.gt);
        check("abort_frozen_eq", eq_cnt, ab.eq);
        check("abort_frozen_lt", lt_cnt, ab.lt);
        check("abort_still_idle", busy, 0);

        // Asynchronous reset mid-sweep, then a clean sweep.
        launch(M_GOOD, 1'b0);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(M_GOOD, 1'b1);
        wait_drained(60);

        // Randomized sweeps: random fault mode, idle gap and ignored re-start.
        repeat (10) begin
            int gap, poke;
            gap  = $urandom_range(0, 5);
            poke = $urandom_range(0, 14);
            repeat (gap) @(negedge clk);
            launch(mode_e'($urandom_range(0, 2)), 1'b1);
            if (poke != 0) begin
                repeat (poke) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_drained(60);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
